uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DBIT, 8, number of data bits per frame; legal values 5 to 8.
REQ-002 Parameter: SB_TICK, 16, stop-bit length in s_tick units (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter: PARITY_EN, 0, 1 inserts one parity bit after the data bits.
REQ-004 Parameter: PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
REQ-005 Port: clk  input  1  system clock; all logic is clocked on the rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: s_tick  input  1  baud-rate enable, 16 pulses per bit time, each one clk wide.
REQ-008 Port: tx_start  input  1  transmit request, sampled on every clk.
REQ-009 Port: din  input  8  byte to send; bits [DBIT-1:0] are used and upper bits are ignored.
REQ-010 Port: tx  output  1  serial line, registered, idle high.
REQ-011 Port: tx_busy  output  1  high from the clk after acceptance until the frame ends.
REQ-012 Port: tx_done_tick  output  1  one-clk pulse at frame completion.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY SHALL be unreachable when PARITY_EN=0.
REQ-014 In IDLE, tx_start=1 SHALL be accepted on any clk edge, independent of s_tick: latch din into the shift register, clear the tick counter and bit counter, compute the parity bit from the latched data, and go to START.
REQ-015 tx_start SHALL be ignored in every state except IDLE; a request raised while busy SHALL NOT be queued.
REQ-016 tx SHALL be 0 in START, shift_reg[0] in DATA, the parity bit in PARITY, and 1 in STOP and IDLE; tx SHALL change on the clk edge that enters the state.
REQ-017 State-exit timing: the tick counter SHALL advance only on s_tick. START, DATA and PARITY SHALL each exit on the s_tick where count==15, and STOP SHALL exit on the s_tick where count==SB_TICK-1. The counter SHALL clear on every exit.
REQ-018 DATA: at count==15, shift the register right by one (LSB first) and increment bit_count; after bit DBIT-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
REQ-019 Parity bit = XOR of data bits [DBIT-1:0], inverted when PARITY_ODD=1.
REQ-020 Frame length SHALL be exactly 16*(1+DBIT+PARITY_EN)+SB_TICK s_tick pulses, measured from the first s_tick after acceptance.
REQ-021 On STOP exit, the block SHALL go to IDLE, assert tx_done_tick for exactly one clk, and drop tx_busy in the same clk.
REQ-022 tx_start=1 in the clk where tx_done_tick=1 SHALL be accepted; back-to-back frames SHALL have no idle bits between the stop bit and the next start bit.
REQ-023 The tick counter SHALL be 5 bits wide so that SB_TICK up to 32 is supported; the bit counter SHALL be 3 bits wide.
REQ-024 din changing after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-025 While reset=1, the block SHALL hold state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, and all counters and the shift register at 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately: tx returns to 1 without waiting for a clk edge, and no tx_done_tick is issued.
REQ-027 After reset deasserts, the first tx_start SHALL produce a complete, well-formed frame.

Verification
REQ-028 Defaults, din=0xA5, s_tick every 4 clk -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks (64 clk) wide; one tx_done_tick; frame length 160 ticks.
REQ-029 PARITY_EN=1, PARITY_ODD=0, din=0xA5 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; frame length 176 ticks.
REQ-030 DBIT=7, SB_TICK=32, din=0xFF -> start bit, seven 1 bits, 2-bit stop; bit 7 is never sent; frame length 160 ticks.
REQ-031 tx_start pulsed mid-frame with din=0x00 -> the current frame (0x3C) completes unchanged and no second frame follows.
REQ-032 tx_start held high continuously, with din changed to 0x55 then 0x0F at each tx_done_tick -> two contiguous frames with no gap and correct bytes.
REQ-033 Reset asserted during DATA bit 3 -> tx=1 immediately, tx_busy=0, no done pulse; a following tx_start of 0x81 is sent correctly.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity bit, SB_TICK-long stop.
// Latency: tx drops to the start bit on the clk edge after tx_start is seen in IDLE; the frame lasts 16*(1+DBIT+PARITY_EN)+SB_TICK s_tick pulses.
// Backpressure: no queueing; tx_start is honoured only while idle (tx_busy=0), including the tx_done_tick clk.
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Last tick index of a 16-tick bit, of the stop period, and the last data bit index.
    localparam logic [4:0] TICK_LAST = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);
    // Only the low DBIT bits of din belong to the frame.
    localparam logic [7:0] DATA_MASK = 8'((1 << DBIT) - 1);
    localparam logic       PAR_INV   = (PARITY_ODD != 0);
    localparam logic       PAR_USED  = (PARITY_EN != 0);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] tick_cnt;
    logic [4:0] tick_cnt_nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic [7:0] shift_reg;
    logic [7:0] shift_nxt;
    logic       par_bit;
    logic       par_nxt;
    logic       tx_reg;
    logic       tx_nxt;
    logic       done_reg;
    logic       done_nxt;
    logic [7:0] din_masked;
    logic       bit_end;

    assign din_masked = din & DATA_MASK;
    // A bit period (START, DATA, PARITY) ends on the s_tick where the count reaches 15.
    assign bit_end    = s_tick && (tick_cnt == TICK_LAST);

    // State register plus datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= 5'd0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'd0;
            par_bit   <= 1'b0;
            tx_reg    <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            par_bit   <= par_nxt;
            tx_reg    <= tx_nxt;
            done_reg  <= done_nxt;
        end
    end

    // Next-state and datapath update: counters advance only on s_tick and clear on every exit.
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift_reg;
        par_nxt      = par_bit;
        case (state)
            IDLE: begin
                // Acceptance does not wait for s_tick; parity is fixed from the latched byte.
                if (tx_start) begin
                    state_nxt    = START;
                    tick_cnt_nxt = 5'd0;
                    bit_cnt_nxt  = 3'd0;
                    shift_nxt    = din_masked;
                    par_nxt      = (^din_masked) ^ PAR_INV;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt    = DATA;
                    tick_cnt_nxt = 5'd0;
                end else if (s_tick) begin
                    tick_cnt_nxt = tick_cnt + 5'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_cnt_nxt = 5'd0;
                    shift_nxt    = {1'b0, shift_reg[7:1]};
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = PAR_USED ? PARITY : STOP;
                    end
                end else if (s_tick) begin
                    tick_cnt_nxt = tick_cnt + 5'd1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt    = STOP;
                    tick_cnt_nxt = 5'd0;
                end else if (s_tick) begin
                    tick_cnt_nxt = tick_cnt + 5'd1;
                end
            end
            STOP: begin
                if (s_tick && (tick_cnt == STOP_LAST)) begin
                    state_nxt    = IDLE;
                    tick_cnt_nxt = 5'd0;
                end else if (s_tick) begin
                    tick_cnt_nxt = tick_cnt + 5'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                tick_cnt_nxt = 5'd0;
                bit_cnt_nxt  = 3'd0;
            end
        endcase
    end

    // Output decode from the state being entered, so tx changes on the entering edge.
    always_comb begin
        tx_nxt   = 1'b1;
        done_nxt = 1'b0;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = par_nxt;
            default: tx_nxt = 1'b1;
        endcase
        if ((state == STOP) && (state_nxt == IDLE)) begin
            done_nxt = 1'b1;
        end
    end

    assign tx           = tx_reg;
    assign tx_busy      = (state != IDLE);
    assign tx_done_tick = done_reg;

endmodule
